fdc_bus_sched: RTL
==================

FDC_BUS_SCHED -- requirements
Module: fdc_bus_sched

Interface
REQ-001 Parameter ADDR_W, default 2: FDC register address width.
REQ-002 Parameter DATA_W, default 8: FDC data bus width.
REQ-003 Port clk, input, 1: 16 MHz system clock; all logic on posedge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Ports cpu_req/dma_req, input, 1 each: access request, held until matching ack.
REQ-006 Ports cpu_we/dma_we, input, 1 each: 1 = write, 0 = read.
REQ-007 Ports cpu_addr/dma_addr, input, ADDR_W each: target register.
REQ-008 Ports cpu_wdata/dma_wdata, input, DATA_W each: write data.
REQ-009 Ports cpu_ack/dma_ack, output, 1 each: one-clk completion pulse.
REQ-010 Ports cpu_rdata/dma_rdata, output, DATA_W each: registered read data.
REQ-011 Port fdc_addr, output, ADDR_W: FDC address bus.
REQ-012 Port fdc_wdata, output, DATA_W: FDC write data.
REQ-013 Port fdc_rdata, input, DATA_W: FDC read data.
REQ-014 Ports fdc_cs_n/fdc_rd_n/fdc_wr_n, output, 1 each: active-low FDC strobes, registered.
REQ-015 Port phase, output, 3: bus-cycle phase; phase[2] is the 2 MHz phi_0 equivalent.

Function
REQ-016 phase SHALL increment by 1 every clk, wrapping 7->0; one bus period = 8 clks.
REQ-017 Arbitration SHALL occur only at phase 7, sampling cpu_req/dma_req/we/addr/wdata of the winner.
REQ-018 FSM states IDLE, SETUP, STROBE, HOLD; IDLE->SETUP at phase 7 with a grant, SETUP (phases 0-1), STROBE (phases 2-5), HOLD (phase 6), HOLD->IDLE at phase 6->7.
REQ-019 SETUP/STROBE/HOLD: fdc_cs_n=0, fdc_addr = granted address; IDLE: fdc_cs_n=1, fdc_addr=0.
REQ-020 STROBE: fdc_rd_n=0 for reads, fdc_wr_n=0 for writes; both 1 in all other states.
REQ-021 fdc_wdata SHALL equal granted wdata during SETUP..HOLD of a write, else 0.
REQ-022 Read data SHALL be captured from fdc_rdata at the last STROBE clk (phase 5) into the granted requester's rdata register; that register holds until its next read.
REQ-023 Granted requester's ack SHALL pulse for exactly one clk during phase 6; at most one ack per period.
REQ-024 Latency: request visible at phase 7 -> ack 7 clks later; max throughput one access per 8 clks.
REQ-025 Request dropped before arbitration: no cycle; dropped after grant: cycle completes, ack still pulses.
REQ-026 Requester still asserting req at phase 7 after its ack SHALL be treated as a new request.
REQ-027 No request at phase 7: FSM stays IDLE for the whole period.

Reset
REQ-028 rst SHALL set, on the next clk: phase=0, FSM=IDLE, cs_n/rd_n/wr_n=1, fdc_addr/fdc_wdata=0, acks=0, both rdata=0, last-grant=DMA.
REQ-029 rst mid-cycle SHALL abort the access with no ack; first arbitration after release at phase 7.

Configuration
REQ-030 Macro FDC_SCHED_RR_EN defined: simultaneous requests resolved round-robin, winner is the one not granted last.
REQ-031 Macro FDC_SCHED_RR_EN undefined: CPU always wins simultaneous requests; last-grant register absent.

Structure
REQ-032 Package fdc_bus_pkg SHALL hold the FSM state enum and phase constants PH_SETUP=0, PH_STROBE=2, PH_SAMPLE=5, PH_ACK=6, PH_ARB=7.
REQ-033 Sub-module fdc_phase_ctr SHALL implement the 3-bit phase counter with synchronous reset; arbitration, FSM and datapath remain in fdc_bus_sched.

Verification
REQ-034 CPU read addr 2, fdc_rdata=0xA5: cs_n low phases 0-6, rd_n low phases 2-5, cpu_ack at phase 6, cpu_rdata=0xA5.
REQ-035 DMA write addr 1 data 0x3C: wr_n low phases 2-5 with fdc_wdata=0x3C, fdc_addr=1, dma_ack at phase 6, cpu_ack stays 0.
REQ-036 Both req held 4 periods with FDC_SCHED_RR_EN: grants CPU, DMA, CPU, DMA; without macro: CPU four times.
REQ-037 rst asserted at phase 3 of a write: next clk wr_n=1, cs_n=1, phase=0, no ack; re-request completes normally.
REQ-038 cpu_req dropped at phase 3 after grant: cycle completes, cpu_ack pulses at phase 6, no cycle in next period.

Source files
------------

// File: rtl/fdc_bus_pkg.sv
// rtl/fdc_bus_pkg.sv - shared FSM state type and bus-cycle phase constants for fdc_bus_sched
package fdc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } fdc_state_t;

    localparam logic [2:0] PH_SETUP  = 3'd0;
    localparam logic [2:0] PH_STROBE = 3'd2;
    localparam logic [2:0] PH_SAMPLE = 3'd5;
    localparam logic [2:0] PH_ACK    = 3'd6;
    localparam logic [2:0] PH_ARB    = 3'd7;

endpackage

// File: rtl/fdc_phase_ctr.sv
// rtl/fdc_phase_ctr.sv - free-running 3-bit bus-cycle phase counter (8 clks per bus period)
module fdc_phase_ctr
    import fdc_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] phase
);

    // Count 0..7 and wrap; reset restarts the period at the setup phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH_SETUP;
        end else begin
            phase <= phase + 3'd1;
        end
    end

endmodule

// File: rtl/fdc_bus_sched.sv
// rtl/fdc_bus_sched.sv - CPU/DMA bus scheduler for the FDC register port; FDC_SCHED_RR_EN enables round-robin arbitration
module fdc_bus_sched
    import fdc_bus_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] fdc_addr,
    output logic [DATA_W-1:0] fdc_wdata,
    input  logic [DATA_W-1:0] fdc_rdata,
    output logic              fdc_cs_n,
    output logic              fdc_rd_n,
    output logic              fdc_wr_n,
    output logic [2:0]        phase
);

    fdc_state_t        state;
    logic              gnt_dma;
    logic              gnt_we;
    logic              pick_cpu;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    fdc_phase_ctr u_phase_ctr (
        .clk   (clk),
        .rst   (rst),
        .phase (phase)
    );

`ifdef FDC_SCHED_RR_EN
    // 1 when DMA held the bus most recently; breaks ties in favour of the other side.
    logic last_grant_dma;
    assign pick_cpu = cpu_req && (!dma_req || last_grant_dma);
`else
    // CPU has fixed priority; DMA only wins when the CPU is not asking.
    assign pick_cpu = cpu_req;
`endif

    // Winner's request fields, sampled only at the arbitration phase.
    always_comb begin
        sel_we    = pick_cpu ? cpu_we    : dma_we;
        sel_addr  = pick_cpu ? cpu_addr  : dma_addr;
        sel_wdata = pick_cpu ? cpu_wdata : dma_wdata;
    end

    // Bus-cycle FSM: all strobes, bus drives, acks and read data are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt_dma   <= 1'b0;
            gnt_we    <= 1'b0;
            fdc_cs_n  <= 1'b1;
            fdc_rd_n  <= 1'b1;
            fdc_wr_n  <= 1'b1;
            fdc_addr  <= '0;
            fdc_wdata <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
`ifdef FDC_SCHED_RR_EN
            last_grant_dma <= 1'b1;
`endif
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (phase == PH_ARB && (cpu_req || dma_req)) begin
                        state     <= ST_SETUP;
                        gnt_dma   <= !pick_cpu;
                        gnt_we    <= sel_we;
                        fdc_cs_n  <= 1'b0;
                        fdc_addr  <= sel_addr;
                        fdc_wdata <= sel_we ? sel_wdata : '0;
`ifdef FDC_SCHED_RR_EN
                        last_grant_dma <= !pick_cpu;
`endif
                    end
                end
                ST_SETUP: begin
                    if (phase == PH_STROBE - 3'd1) begin
                        state    <= ST_STROBE;
                        fdc_rd_n <= gnt_we;
                        fdc_wr_n <= !gnt_we;
                    end
                end
                ST_STROBE: begin
                    if (phase == PH_SAMPLE) begin
                        state    <= ST_HOLD;
                        fdc_rd_n <= 1'b1;
                        fdc_wr_n <= 1'b1;
                        cpu_ack  <= !gnt_dma;
                        dma_ack  <= gnt_dma;
                        if (!gnt_we && !gnt_dma) cpu_rdata <= fdc_rdata;
                        if (!gnt_we && gnt_dma)  dma_rdata <= fdc_rdata;
                    end
                end
                ST_HOLD: begin
                    if (phase == PH_ACK) begin
                        state     <= ST_IDLE;
                        fdc_cs_n  <= 1'b1;
                        fdc_addr  <= '0;
                        fdc_wdata <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
